// File: rtl/bcd_conv_scheduler.sv
// Shared binary-to-BCD converter: round-robin arbitration over NREQ requesters,
// one double-dabble shift-add-3 iteration per clock, four-digit BCD result.
module bcd_conv_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] bin_in,
    output logic [NREQ-1:0]       done,
    output logic [15:0]           bcd_out,
    output logic                  busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_gnt;
    logic [WIDTH-1:0]   r_bin;
    logic [15:0]        r_bcd;
    logic [CW-1:0]      r_cnt;
    logic [NREQ-1:0]    r_done;
    logic [15:0]        r_bcd_out;
    logic               r_busy;

    logic [WIDTH-1:0]   w_bin_arr [NREQ];
    logic [PW-1:0]      w_gnt_idx;
    logic [WIDTH-1:0]   w_bin_sel;
    logic [15:0]        w_bcd_adj;
    logic [15+WIDTH:0]  w_cat;
    logic [15+WIDTH:0]  w_cat_sh;
    logic [15:0]        w_bcd_next;
    logic [WIDTH-1:0]   w_bin_next;
    logic [PW-1:0]      w_ptr_next;

    // First requester at or after ptr, wrapping; lowest offset wins.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] rq,
                                              input logic [PW-1:0]   p);
        logic [PW-1:0] g;
        int            idx;
        g = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(p) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (rq[idx[PW-1:0]]) g = idx[PW-1:0];
        end
        return g;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign w_bin_arr[gi] = bin_in[gi*WIDTH +: WIDTH];
        end
        // Corrected nibbles never exceed 12, so no carry crosses digits.
        for (gi = 0; gi < 4; gi++) begin : g_add3
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5)
                                        ? r_bcd[gi*4 +: 4] + 4'd3
                                        : r_bcd[gi*4 +: 4];
        end
    endgenerate

    assign w_gnt_idx  = rr_pick(req, r_ptr);
    assign w_bin_sel  = w_bin_arr[w_gnt_idx];
    assign w_cat      = {w_bcd_adj, r_bin};
    assign w_cat_sh   = w_cat << 1;
    assign w_bcd_next = w_cat_sh[15+WIDTH:WIDTH];
    assign w_bin_next = w_cat_sh[WIDTH-1:0];
    assign w_ptr_next = (r_gnt == PW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_done    <= '0;
            r_bcd_out <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_gnt   <= w_gnt_idx;
                        r_bin   <= w_bin_sel;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= w_bcd_next;
                    r_bin <= w_bin_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_done    <= NREQ'(1) << r_gnt;
                        r_bcd_out <= w_bcd_next;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ptr   <= w_ptr_next;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign done    = r_done;
    assign bcd_out = r_bcd_out;
    assign busy    = r_busy;

endmodule

// File: doc/bcd_conv_scheduler.md
# bcd_conv_scheduler

Shared, sequential binary-to-BCD conversion engine for the clock display path. Up to NREQ requesters (year, day, hour/minute counters, etc.) each present a binary value and a request. A round-robin arbiter grants one at a time and converts it with a one-bit-per-cycle shift-add-3 (double-dabble) datapath. The four-digit BCD result is returned with a one-cycle done pulse to the granted requester. This replaces per-field combinational subtract-compare converters with a single small sequential unit.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 12, binary input width per requester (1..13; 13 bits caps input at 8191, within 4 BCD digits)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active low, sampled on rising edge of clk
- req  in  NREQ  level request per requester; held high until its done pulse
- bin_in  in  NREQ*WIDTH  requester i's value in bits [i*WIDTH +: WIDTH]
- done  out  NREQ  one-hot, one-cycle pulse to the requester whose result is on bcd_out
- bcd_out  out  16  {thousands, hundreds, tens, ones}, 4 bits each
- busy  out  1  high in SHIFT and DONE states

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If req is nonzero, pick the granted index g by round-robin, starting the search at ptr and wrapping.
  - Latch bin_in slice g into the binary shift register and clear the 16-bit BCD accumulator.
  - Clear the bit counter, store g, and go to SHIFT.
  - If req is zero, stay in IDLE.
- SHIFT, one iteration per cycle, WIDTH cycles:
  - For each BCD nibble ≥ 5, add 3.
  - Shift {bcd, bin} left by one; the binary MSB enters BCD bit 0.
  - Increment the counter. When the counter reaches WIDTH-1 on this edge, go to DONE.
- DONE:
  - Exactly one cycle. bcd_out holds the result and done[g] = 1.
  - Set ptr to (g+1) mod NREQ, then go to IDLE.
- bin_in is sampled only at the grant edge. Later changes do not affect an in-flight conversion.
- req deasserted mid-conversion: the conversion completes and done[g] still pulses; the requester ignores it.
- A requester re-raising req after done is eligible again, but after every other pending requester (round-robin).
- bcd_out holds the last result until the next DONE update; it is not cleared on IDLE.
- Add-3 uses 4-bit nibble arithmetic. No carry crosses nibbles, because corrected nibbles never exceed 12 before the shift.

## Timing
- Reset values:
  - state = IDLE, ptr = 0
  - done = 0, busy = 0, bcd_out = 16'h0000
  - internal shift registers and counter = 0
- Reset asserted mid-conversion:
  - The next edge forces all of the reset values above.
  - No done pulse is emitted for the aborted conversion.
- Latency:
  - Grant edge E0 (IDLE with req ≠ 0); shifts occur on edges E1..E_WIDTH.
  - DONE state is entered at edge E_WIDTH; done and bcd_out are valid in the cycle after E_WIDTH.
  - Equivalently, result valid WIDTH cycles after leaving IDLE (12 for the default).
- Throughput: one conversion per WIDTH+2 cycles (IDLE + WIDTH×SHIFT + DONE); 14 cycles for the default.
- done is registered and never high for two consecutive cycles.
- At most one done bit is high at any time.
- busy falls in the cycle IDLE is re-entered.
- Simultaneous requests: exactly one grant per IDLE cycle; the others wait, with req held.

## Test plan
- Single conversion: WIDTH=12, req=4'b0001, bin_in[11:0]=2025.
  - done=4'b0001 pulses exactly 13 edges after req is first sampled in IDLE.
  - bcd_out = 16'h2025.
- Value sweep on requester 2: 0, 9, 10, 999, 3025, 4095.
  - bcd_out = 16'h0000, 16'h0009, 16'h0010, 16'h0999, 16'h3025, 16'h4095.
  - Full exhaustive 0..4095 sweep checked against a reference model.
- Arbitration: req=4'b1011 held, each bit dropped one cycle after its done.
  - done order 0, 1, 3, with 14-cycle spacing between pulses.
  - Re-raising req[0] while req[1] is pending yields 1 before 0.
- Input change during SHIFT: change bin_in slice g from 2025 to 3000 mid-conversion.
  - Result is still 16'h2025.
  - Dropping req[g] mid-conversion still produces the done[g] pulse.
- Reset mid-conversion: assert rst_n=0 for one cycle during SHIFT.
  - Next cycle: busy=0, done=0, bcd_out=16'h0000, ptr=0.
  - A new req=4'b0100 with 1234 yields 16'h1234 with normal latency.
- Idle/protocol checks (assertions):
  - done is one-hot or zero and never high for two consecutive cycles.
  - busy=0 whenever state is IDLE.
  - bcd_out is stable outside DONE-entry edges.
